// File: rtl/fb_draw_seq_if.sv
// Renderer handshake and registered framebuffer write port of fb_draw_seq.
// slave = sequencer side, master = renderer/framebuffer side.
interface fb_draw_seq_if #(
  parameter int ADDRW = 16,
  parameter int DATAW = 4
) ();
  logic             render_start;
  logic             render_done;
  logic             render_we;
  logic [ADDRW-1:0] render_addr;
  logic [DATAW-1:0] render_colr;
  logic             fb_we;
  logic [ADDRW-1:0] fb_addr;
  logic [DATAW-1:0] fb_colr;

  modport slave (
    input  render_done, render_we, render_addr, render_colr,
    output render_start, fb_we, fb_addr, fb_colr
  );

  modport master (
    output render_done, render_we, render_addr, render_colr,
    input  render_start, fb_we, fb_addr, fb_colr
  );
endinterface

// File: rtl/fb_draw_seq.sv
// Framebuffer draw sequencer: buffer selection, clear and render hand-off for
// double (swap at frame) or triple (free-running render, present latest) buffering.
module fb_draw_seq #(
  parameter int ADDRW     = 16,
  parameter int DATAW     = 4,
  parameter int PIXELS    = 57600,
  parameter int NBUF      = 2,
  parameter int CLEAR_EN  = 1,
  parameter int LAT_DRAIN = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_i,
  input  logic [DATAW-1:0] clear_colr_i,
  fb_draw_seq_if.slave     bus,
  output logic [1:0]       buf_draw_o,
  output logic [1:0]       buf_disp_o,
  output logic             busy_o,
  output logic [7:0]       skip_cnt_o
);

  localparam int               DRW      = (LAT_DRAIN > 1) ? $clog2(LAT_DRAIN) : 1;
  localparam logic [ADDRW-1:0] CLR_LAST = ADDRW'(PIXELS - 1);
  localparam logic [DRW-1:0]   DRN_LAST = DRW'(LAT_DRAIN - 1);
  localparam bit               TRIPLE   = (NBUF == 3);

  if (NBUF != 2 && NBUF != 3) begin : g_nbuf_check
    $error("fb_draw_seq: NBUF must be 2 or 3");
  end

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_CLEAR, S_DRAW, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [ADDRW-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATAW-1:0] clr_colr_q, clr_colr_d;
  logic [DRW-1:0]   drain_q, drain_d;
  logic             start_q, start_d;
  logic             we_q, we_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [DATAW-1:0] colr_q, colr_d;
  logic [1:0]       disp_q, disp_d;
  logic [1:0]       draw_q, draw_d;
  logic [1:0]       rdy_q, rdy_d;
  logic             rdy_v_q, rdy_v_d;
  logic [7:0]       skip_q, skip_d;
  logic             skip_inc;

  logic clr_last, drn_last, done_fire;
  assign clr_last  = (clr_cnt_q == CLR_LAST);
  assign drn_last  = (drain_q == DRN_LAST);
  assign done_fire = (state_q == S_DONE) && drn_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (frame_i) state_d = S_INIT;
      S_INIT:  state_d = (CLEAR_EN != 0) ? S_CLEAR : S_DRAW;
      S_CLEAR: if (clr_last) state_d = S_DRAW;
      S_DRAW:  if (bus.render_done) state_d = S_DONE;
      S_DONE:  if (drn_last) state_d = TRIPLE ? S_INIT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Write-port source select; every output is registered one cycle behind its source.
  always_comb begin
    clr_cnt_d  = clr_cnt_q;
    clr_colr_d = clr_colr_q;
    drain_d    = '0;
    start_d    = (state_d == S_DRAW) && (state_q != S_DRAW);
    we_d       = 1'b0;
    addr_d     = '0;
    colr_d     = '0;
    case (state_q)
      S_INIT: begin
        clr_cnt_d  = '0;
        clr_colr_d = clear_colr_i;
      end
      S_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        we_d      = 1'b1;
        addr_d    = clr_cnt_q;
        colr_d    = clr_colr_q;
      end
      S_DRAW: begin
        we_d   = bus.render_we;
        addr_d = bus.render_addr;
        colr_d = bus.render_colr;
      end
      S_DONE: begin
        we_d    = bus.render_we;
        addr_d  = bus.render_addr;
        colr_d  = bus.render_colr;
        drain_d = drn_last ? '0 : drain_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Buffer bookkeeping. In triple mode a frame consumes the old ready buffer before a
  // coincident completion publishes the new one; indices 0+1+2=3 give the free buffer.
  always_comb begin
    disp_d   = disp_q;
    draw_d   = draw_q;
    rdy_d    = rdy_q;
    rdy_v_d  = rdy_v_q;
    skip_inc = 1'b0;
    if (!TRIPLE) begin
      if (frame_i) begin
        if (state_q == S_IDLE) begin
          disp_d = draw_q;
          draw_d = disp_q;
        end else begin
          skip_inc = 1'b1;
        end
      end
    end else begin
      if (frame_i && rdy_v_q) begin
        disp_d  = rdy_q;
        rdy_v_d = 1'b0;
      end
      if (done_fire) begin
        skip_inc = rdy_v_q && !frame_i;
        rdy_d    = draw_q;
        rdy_v_d  = 1'b1;
        draw_d   = 2'd3 - disp_d - draw_q;
      end
    end
    skip_d = (skip_inc && skip_q != 8'hFF) ? skip_q + 8'd1 : skip_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt_q  <= '0;
      clr_colr_q <= '0;
      drain_q    <= '0;
      start_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      colr_q     <= '0;
      disp_q     <= 2'd0;
      draw_q     <= 2'd1;
      rdy_q      <= 2'd0;
      rdy_v_q    <= 1'b0;
      skip_q     <= '0;
    end else begin
      clr_cnt_q  <= clr_cnt_d;
      clr_colr_q <= clr_colr_d;
      drain_q    <= drain_d;
      start_q    <= start_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      colr_q     <= colr_d;
      disp_q     <= disp_d;
      draw_q     <= draw_d;
      rdy_q      <= rdy_d;
      rdy_v_q    <= rdy_v_d;
      skip_q     <= skip_d;
    end
  end

  assign bus.render_start = start_q;
  assign bus.fb_we        = we_q;
  assign bus.fb_addr      = addr_q;
  assign bus.fb_colr      = colr_q;
  assign buf_draw_o       = draw_q;
  assign buf_disp_o       = disp_q;
  assign busy_o           = (state_q != S_IDLE);
  assign skip_cnt_o       = skip_q;

endmodule
